operand_latch: RTL
==================

OPERAND_LATCH -- requirements
Module: operand_latch

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, consecutive stable clk cycles required to accept a new input level (minimum 2).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: sw_raw  input  4  unsynchronised slide switches, bit3..0 = A1, A2, B1, B2.
REQ-005 Port: btn_raw  input  1  unsynchronised load push-button, active-high, bouncing.
REQ-006 Port: A1  output  1  latched operand A bit 1 (to adder/display stage).
REQ-007 Port: A2  output  1  latched operand A bit 0.
REQ-008 Port: B1  output  1  latched operand B bit 1.
REQ-009 Port: B2  output  1  latched operand B bit 0.
REQ-010 Port: load_pulse  output  1  one-cycle strobe on the edge A1..B2 update.
REQ-011 Port: busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-012 sw_raw and btn_raw SHALL each pass through a 2-flop synchroniser (sw_s, btn_s) before any other use.
REQ-013 Switch debounce: a counter SHALL restart at 0 whenever sw_s differs from its previous-cycle value, and sw_stable SHALL load sw_s on the edge where sw_s has been unchanged for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 Button debounce counter width SHALL be ceil(log2(DEBOUNCE_CYCLES))+1 bits and SHALL saturate, never wrap.
REQ-015 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-016 IDLE: btn_s=1 -> PRESS_WAIT, counter cleared; else stay.
REQ-017 PRESS_WAIT: btn_s=0 -> IDLE (bounce rejected, no latch); btn_s=1 for DEBOUNCE_CYCLES consecutive cycles -> HELD, and on that same edge A1..B2 SHALL load sw_stable[3..0] and load_pulse SHALL assert for exactly one cycle.
REQ-018 HELD: btn_s=0 -> RELEASE_WAIT, counter cleared; holding the button SHALL never produce a second latch.
REQ-019 RELEASE_WAIT: btn_s=1 -> HELD (release bounce); btn_s=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
REQ-020 Latency: latch edge SHALL occur exactly 2 + DEBOUNCE_CYCLES clk edges after the first clean rising edge of btn_raw.
REQ-021 Simultaneous switch change and latch: the latch SHALL use sw_stable as held before that edge; a switch change not yet debounced SHALL NOT appear on A1..B2.
REQ-022 A1..B2 SHALL change only on a load_pulse edge or on reset; sw_raw activity alone SHALL never alter them.
REQ-023 busy SHALL be a registered decode of state, 0 only in IDLE.

Reset
REQ-024 rst=1 SHALL immediately, without clk, force A1=A2=B1=B2=0, load_pulse=0, busy=0, state=IDLE, all counters, synchronisers and sw_stable to 0.
REQ-025 Reset asserted mid-PRESS_WAIT or HELD SHALL abort with no latch; after release, a new full press is required.
REQ-026 First capture after reset deassertion SHALL follow REQ-020 timing with no shortened count.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 sw_raw=4'b1001 held 10 cycles, then btn_raw=1 clean -> load_pulse high for 1 cycle 6 edges after btn rise; A1=1, A2=0, B1=0, B2=1; busy=1 until 4 cycles after btn release synchronised.
REQ-028 btn_raw toggled 1,0,1,0 each cycle then 0 -> no load_pulse, A1..B2 unchanged, FSM returns to IDLE.
REQ-029 Button held 50 cycles with sw_raw changed to 4'b0110 mid-hold -> exactly one load_pulse, outputs keep the pre-hold value.
REQ-030 sw_raw=4'b1111 applied 2 cycles before btn press debounces -> latch captures old sw_stable, not 4'b1111; next press captures 4'b1111.
REQ-031 rst pulsed asynchronously mid-PRESS_WAIT with outputs at 4'b1010 -> outputs 0 within the same timestep, no load_pulse, busy=0.
REQ-032 Release bounce 0,1,0 in RELEASE_WAIT then held 0 -> returns to HELD on the 1, reaches IDLE after 4 clean low cycles, no extra load_pulse.

Source files
------------

// File: rtl/operand_latch.sv
// operand_latch: synchronises four operand switches and a load push-button,
// debounces both, and on each accepted button press latches the debounced
// switch word onto A1/A2/B1/B2 with a one-cycle load_pulse strobe.
module operand_latch #(
  // Consecutive stable clk cycles needed to accept a new level (minimum 2).
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_raw,
  input  logic       btn_raw,
  output logic       A1,
  output logic       A2,
  output logic       B1,
  output logic       B2,
  output logic       load_pulse,
  output logic       busy
);

  // One extra bit above log2 so the button counter can saturate without wrapping.
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  // Switch counter value at which the word has been unchanged long enough.
  localparam logic [CW-1:0] SW_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  // The IDLE/HELD edge that sees the first new button level counts as one
  // cycle, so the wait states finish when the counter reaches D-2.
  localparam logic [CW-1:0] BTN_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [3:0]    sw_meta;
  logic [3:0]    sw_s;
  logic          btn_meta;
  logic          btn_s;
  logic [3:0]    sw_prev;
  logic [3:0]    sw_stable;
  logic [CW-1:0] sw_cnt;
  logic [CW-1:0] btn_cnt;
  state_t        state;

  // Two-flop synchronisers for the asynchronous switch and button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_s     <= '0;
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      sw_meta  <= sw_raw;
      sw_s     <= sw_meta;
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
    end
  end

  // Switch debounce: any change restarts the count; a word that stays put
  // long enough is copied into sw_stable (re-copied harmlessly thereafter).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_prev   <= '0;
      sw_cnt    <= '0;
      sw_stable <= '0;
    end else begin
      sw_prev <= sw_s;
      if (sw_s != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt != SW_LAST) begin
        sw_cnt <= sw_cnt + 1'b1;
      end else begin
        sw_stable <= sw_s;
      end
    end
  end

  // Button FSM with registered operand outputs, load strobe and busy flag.
  // busy is written alongside every state change so it always mirrors the
  // registered state (low only in IDLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      btn_cnt    <= '0;
      A1         <= 1'b0;
      A2         <= 1'b0;
      B1         <= 1'b0;
      B2         <= 1'b0;
      load_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      case (state)
        IDLE: begin
          btn_cnt <= '0;
          if (btn_s) begin
            state <= PRESS_WAIT;
            busy  <= 1'b1;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            // Bounce rejected: nothing is latched.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (btn_cnt == BTN_LAST) begin
            // Latch the word debounced before this edge, never a fresh one.
            state      <= HELD;
            A1         <= sw_stable[3];
            A2         <= sw_stable[2];
            B1         <= sw_stable[1];
            B2         <= sw_stable[0];
            load_pulse <= 1'b1;
          end else begin
            btn_cnt <= (btn_cnt == CNT_MAX) ? btn_cnt : btn_cnt + 1'b1;
          end
        end
        HELD: begin
          // Holding the button never re-latches; only a release moves on.
          if (!btn_s) begin
            state   <= RELEASE_WAIT;
            btn_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
          end else if (btn_cnt == BTN_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            btn_cnt <= (btn_cnt == CNT_MAX) ? btn_cnt : btn_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
